system_bus_ctrl: RTL and testbench

Parametrised memory-backed slave for the MCU-32X system bus, succeeding the fixed 32-bit/1024-word bus memory. It adds configurable data width, depth, base address and wait states, per-byte write enables, a valid/ready request/response handshake with back-pressure, and an error response for misaligned or out-of-range accesses. It sits between the core's load/store unit and on-chip RAM. At most one transaction is outstanding at a time.

---
 rtl/system_bus_ctrl.sv | 161 ++++++++++++++++
 tb/tb_system_bus_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/system_bus_ctrl.sv
// Memory-backed system bus slave with a valid/ready request/response handshake.
// One transaction in flight, configurable wait states, byte-lane writes and error responses.
module system_bus_ctrl #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = {ADDR_W{1'b0}},
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned       BE_W       = DATA_W / 8;
    localparam int unsigned       LB         = $clog2(BE_W);
    localparam int unsigned       IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BE_W - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
    localparam logic [3:0]        WS_INIT    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Offset is modular, so addresses below the base wrap high and fail the range check.
    function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return off >> LB;
    endfunction

    function automatic logic access_error(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return ((off & ALIGN_MASK) != {ADDR_W{1'b0}}) || ((off >> LB) >= DEPTH_A);
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              commit_s;
    logic              mem_we_s;

    assign commit_s  = (state_q == ST_BUSY) && (wcnt_q == 4'd0);
    assign mem_we_s  = commit_s && wr_q && !err_q;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and response computation for the transaction FSM
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    idx_d   = IDX_W'(word_index(req_addr));
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = access_error(req_addr);
                    wcnt_d  = WS_INIT;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    // Writes and failed accesses never return memory contents.
                    rsp_rdata_d = (err_q || wr_q) ? {DATA_W{1'b0}} : mem_q[idx_q];
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // FSM, request latch and registered response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 4'd0;
            wr_q        <= 1'b0;
            idx_q       <= {IDX_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            be_q        <= {BE_W{1'b0}};
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            wr_q        <= wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane write port of the storage array; contents are intentionally not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BE_W); i++) begin
            if (mem_we_s && be_q[i]) begin
                mem_q[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_system_bus_ctrl.sv
// Directed bench for system_bus_ctrl: three instances cover default, offset-base/wait-state
// and 64-bit/small-depth configurations.
module tb_system_bus_ctrl;

    logic clk;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    // u0: defaults (32-bit, 1024 words, base 0, no wait states)
    logic        r0_n, v0, rdy0, w0, rv0, rr0, e0;
    logic [31:0] a0, wd0, rd0;
    logic [3:0]  be0;
    // u1: base 0x1000, 3 wait states
    logic        r1_n, v1, rdy1, w1, rv1, rr1, e1;
    logic [31:0] a1, wd1, rd1;
    logic [3:0]  be1;
    // u2: 64-bit, 16 words, 2 wait states
    logic        r2_n, v2, rdy2, w2, rv2, rr2, e2;
    logic [31:0] a2;
    logic [63:0] wd2, rd2;
    logic [7:0]  be2;

    system_bus_ctrl u0 (
        .clk(clk), .reset_n(r0_n), .req_valid(v0), .req_ready(rdy0), .req_write(w0),
        .req_addr(a0), .req_wdata(wd0), .req_be(be0), .rsp_valid(rv0), .rsp_ready(rr0),
        .rsp_rdata(rd0), .rsp_err(e0)
    );

    system_bus_ctrl #(.BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) u1 (
        .clk(clk), .reset_n(r1_n), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_addr(a1), .req_wdata(wd1), .req_be(be1), .rsp_valid(rv1), .rsp_ready(rr1),
        .rsp_rdata(rd1), .rsp_err(e1)
    );

    system_bus_ctrl #(.DATA_W(64), .DEPTH(16), .WAIT_STATES(2)) u2 (
        .clk(clk), .reset_n(r2_n), .req_valid(v2), .req_ready(rdy2), .req_write(w2),
        .req_addr(a2), .req_wdata(wd2), .req_be(be2), .rsp_valid(rv2), .rsp_ready(rr2),
        .rsp_rdata(rd2), .rsp_err(e2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int u, input logic v, input logic wr, input logic [31:0] addr,
                             input logic [63:0] wd, input logic [7:0] be);
        case (u)
            0: begin v0 = v; w0 = wr; a0 = addr; wd0 = wd[31:0]; be0 = be[3:0]; end
            1: begin v1 = v; w1 = wr; a1 = addr; wd1 = wd[31:0]; be1 = be[3:0]; end
            default: begin v2 = v; w2 = wr; a2 = addr; wd2 = wd; be2 = be; end
        endcase
    endtask

    task automatic set_rr(input int u, input logic r);
        case (u)
            0: rr0 = r;
            1: rr1 = r;
            default: rr2 = r;
        endcase
    endtask

    function automatic logic get_rdy(input int u);
        case (u)
            0: return rdy0;
            1: return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_rv(input int u);
        case (u)
            0: return rv0;
            1: return rv1;
            default: return rv2;
        endcase
    endfunction

    function automatic logic get_err(input int u);
        case (u)
            0: return e0;
            1: return e1;
            default: return e2;
        endcase
    endfunction

    function automatic logic [63:0] get_rd(input int u);
        case (u)
            0: return {32'd0, rd0};
            1: return {32'd0, rd1};
            default: return rd2;
        endcase
    endfunction

    // Full transaction, called and returning at a falling edge. hold = cycles of back-pressure.
    task automatic txn(input int u, input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] be, input int hold, input int ws,
                       output logic [63:0] rdata, output logic err, output int acc);
        int k;
        int rise;
        set_rr(u, hold == 0);
        drive_req(u, 1'b1, wr, addr, wd, be);
        k = 0;
        while (!get_rdy(u) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("accept_ready", 64'(get_rdy(u)), 64'd1);
        @(negedge clk);
        acc = cyc;
        drive_req(u, 1'b0, 1'b0, 32'd0, 64'd0, 8'd0);
        k = 0;
        while (!get_rv(u) && k < 50) begin
            check_val("ready_low_busy", 64'(get_rdy(u)), 64'd0);
            @(negedge clk);
            k++;
        end
        rise = cyc;
        check_val("rsp_latency", 64'(rise - acc), 64'(ws + 1));
        rdata = get_rd(u);
        err   = get_err(u);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("bp_valid", 64'(get_rv(u)), 64'd1);
            check_val("bp_ready", 64'(get_rdy(u)), 64'd0);
            check_val("bp_rdata", get_rd(u), rdata);
            check_val("bp_err", 64'(get_err(u)), 64'(err));
        end
        set_rr(u, 1'b1);
        @(negedge clk);
        check_val("rsp_done", 64'(get_rv(u)), 64'd0);
        check_val("ready_after", 64'(get_rdy(u)), 64'd1);
    endtask

    logic [63:0] rd;
    logic        er;
    int          ta, tb;

    initial begin
        r0_n = 1'b0; r1_n = 1'b0; r2_n = 1'b0;
        rr0 = 1'b0; rr1 = 1'b0; rr2 = 1'b0;
        drive_req(0, 1'b1, 1'b0, 32'h0, 64'd0, 8'h0);
        drive_req(1, 1'b0, 1'b0, 32'h0, 64'd0, 8'h0);
        drive_req(2, 1'b0, 1'b0, 32'h0, 64'd0, 8'h0);
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check_val($sformatf("rst_ready_u%0d", u), 64'(get_rdy(u)), 64'd1);
            check_val($sformatf("rst_valid_u%0d", u), 64'(get_rv(u)), 64'd0);
            check_val($sformatf("rst_rdata_u%0d", u), get_rd(u), 64'd0);
            check_val($sformatf("rst_err_u%0d", u), 64'(get_err(u)), 64'd0);
        end
        drive_req(0, 1'b0, 1'b0, 32'h0, 64'd0, 8'h0);
        r0_n = 1'b1; r1_n = 1'b1; r2_n = 1'b1;
        @(negedge clk);

        // Reset then read: contents undefined, only timing and error flag checked
        txn(0, 1'b0, 32'h0, 64'd0, 8'h0, 0, 0, rd, er, ta);
        check_val("first_read_err", 64'(er), 64'd0);

        // Byte-enable merging
        txn(0, 1'b1, 32'h10, 64'h1122_3344, 8'hF, 0, 0, rd, er, ta);
        check_val("wr_full_rdata", rd, 64'd0);
        check_val("wr_full_err", 64'(er), 64'd0);
        txn(0, 1'b1, 32'h10, 64'hAABB_CCDD, 8'h5, 0, 0, rd, er, ta);
        check_val("wr_be5_err", 64'(er), 64'd0);
        txn(0, 1'b0, 32'h10, 64'd0, 8'h0, 0, 0, rd, er, ta);
        check_val("be_merge", rd, 64'h11BB_33DD);
        txn(0, 1'b1, 32'h10, 64'hFFFF_FFFF, 8'h0, 0, 0, rd, er, ta);
        check_val("be0_err", 64'(er), 64'd0);
        txn(0, 1'b0, 32'h10, 64'd0, 8'hF, 0, 0, rd, er, ta);
        check_val("be0_noop", rd, 64'h11BB_33DD);

        // Error responses on the offset-base instance
        txn(1, 1'b1, 32'h1000, 64'hCAFE_F00D, 8'hF, 0, 3, rd, er, ta);
        check_val("base_wr_err", 64'(er), 64'd0);
        txn(1, 1'b0, 32'h1002, 64'd0, 8'h0, 0, 3, rd, er, ta);
        check_val("misalign_err", 64'(er), 64'd1);
        check_val("misalign_rdata", rd, 64'd0);
        txn(1, 1'b0, 32'h2000, 64'd0, 8'h0, 0, 3, rd, er, ta);
        check_val("range_err", 64'(er), 64'd1);
        check_val("range_rdata", rd, 64'd0);
        txn(1, 1'b0, 32'h0FFC, 64'd0, 8'h0, 0, 3, rd, er, ta);
        check_val("below_err", 64'(er), 64'd1);
        check_val("below_rdata", rd, 64'd0);
        txn(1, 1'b1, 32'h1002, 64'hBAD0_BAD0, 8'hF, 0, 3, rd, er, ta);
        check_val("wr_misalign_err", 64'(er), 64'd1);
        txn(1, 1'b1, 32'h2000, 64'hBAD1_BAD1, 8'hF, 0, 3, rd, er, ta);
        check_val("wr_range_err", 64'(er), 64'd1);

        // Wait states plus 5 cycles of back-pressure; also shows word 0 survived bad writes
        txn(1, 1'b0, 32'h1000, 64'd0, 8'h0, 5, 3, rd, er, ta);
        check_val("base_intact", rd, 64'hCAFE_F00D);
        check_val("base_rd_err", 64'(er), 64'd0);

        // Reset while a write is still counting wait states
        txn(1, 1'b1, 32'h1020, 64'h0102_0304, 8'hF, 0, 3, rd, er, ta);
        drive_req(1, 1'b1, 1'b1, 32'h1020, 64'hDEAD_BEEF, 8'hF);
        @(negedge clk);
        drive_req(1, 1'b0, 1'b0, 32'h0, 64'd0, 8'h0);
        check_val("abort_accepted", 64'(rdy1), 64'd0);
        repeat (2) @(negedge clk);
        r1_n = 1'b0;
        #1;
        check_val("abort_async_ready", 64'(rdy1), 64'd1);
        check_val("abort_async_valid", 64'(rv1), 64'd0);
        repeat (2) @(negedge clk);
        r1_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("abort_no_rsp", 64'(rv1), 64'd0);
        end
        txn(1, 1'b0, 32'h1020, 64'd0, 8'h0, 0, 3, rd, er, ta);
        check_val("abort_old_data", rd, 64'h0102_0304);

        // 64-bit instance: last word, back-to-back spacing, partial lanes, bounds
        txn(2, 1'b1, 32'h78, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 2, rd, er, ta);
        txn(2, 1'b0, 32'h78, 64'd0, 8'h0, 0, 2, rd, er, tb);
        check_val("last_word", rd, 64'h0123_4567_89AB_CDEF);
        check_val("accept_spacing", 64'(tb - ta), 64'd5);
        txn(2, 1'b1, 32'h78, 64'hAAAA_AAAA_BBBB_BBBB, 8'hF0, 0, 2, rd, er, ta);
        txn(2, 1'b0, 32'h78, 64'd0, 8'h0, 0, 2, rd, er, tb);
        check_val("upper_lanes", rd, 64'hAAAA_AAAA_89AB_CDEF);
        txn(2, 1'b0, 32'h80, 64'd0, 8'h0, 0, 2, rd, er, ta);
        check_val("w64_range_err", 64'(er), 64'd1);
        txn(2, 1'b0, 32'h7C, 64'd0, 8'h0, 0, 2, rd, er, ta);
        check_val("w64_misalign_err", 64'(er), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
